// File: rtl/fwd_ctrl.sv
// Forwarding control for a three-stage ID/EX/WB pipeline.
// Tracks the producer in EX and registers operand/store-data select codes for the consumer entering EX.
module fwd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_id_valid,
  input  logic [4:0]       io_id_rs1,
  input  logic [4:0]       io_id_rs2,
  input  logic             io_id_uses_rs1,
  input  logic             io_id_uses_rs2,
  input  logic [4:0]       io_id_rd,
  input  logic             io_id_regwen,
  input  logic             io_id_is_load,
  input  logic             io_id_a_pc,
  input  logic             io_id_b_imm,
  input  logic             io_stall,
  input  logic             io_flush,
  input  logic             io_perf_clear,
  output logic [1:0]       io_a_sel,
  output logic [1:0]       io_b_sel,
  output logic [1:0]       io_rs2_sel,
  output logic             io_ex_valid,
  output logic [CNT_W-1:0] io_fwd_alu_cnt,
  output logic [CNT_W-1:0] io_fwd_mem_cnt
);

  // Select encodings shared by the A, B and store-data muxes in EX.
  localparam logic [1:0] SEL_REG = 2'd0;  // register file operand
  localparam logic [1:0] SEL_ALT = 2'd1;  // pc for A, immediate for B
  localparam logic [1:0] SEL_ALU = 2'd2;  // producer's ALU result
  localparam logic [1:0] SEL_MEM = 2'd3;  // producer's load data

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Producer currently in EX.
  logic [4:0]       ex_rd;
  logic             ex_regwen;
  logic             ex_is_load;
  logic             ex_valid;

  logic [1:0]       a_sel_q, b_sel_q, rs2_sel_q;
  logic [CNT_W-1:0] alu_cnt_q, mem_cnt_q;

  logic             producer_live;
  logic             hit_rs1, hit_rs2;
  logic [1:0]       fwd_code;
  logic [1:0]       fc_rs1, fc_rs2;
  logic [1:0]       a_sel_nxt, b_sel_nxt, rs2_sel_nxt;
  logic             rs1_counts, rs2_counts;
  logic             alu_inc, mem_inc;
  logic             advance;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    producer_live = 1'b0;
    hit_rs1       = 1'b0;
    hit_rs2       = 1'b0;
    fwd_code      = SEL_REG;
    fc_rs1        = SEL_REG;
    fc_rs2        = SEL_REG;
    a_sel_nxt     = SEL_REG;
    b_sel_nxt     = SEL_REG;
    rs2_sel_nxt   = SEL_REG;
    rs1_counts    = 1'b0;
    rs2_counts    = 1'b0;
    alu_inc       = 1'b0;
    mem_inc       = 1'b0;

    // x0 is hardwired zero, so a write to it is never a real dependency.
    producer_live = ex_valid & ex_regwen & (ex_rd != 5'd0);
    fwd_code      = ex_is_load ? SEL_MEM : SEL_ALU;

    hit_rs1 = io_id_valid & producer_live & io_id_uses_rs1 & (ex_rd == io_id_rs1);
    hit_rs2 = io_id_valid & producer_live & io_id_uses_rs2 & (ex_rd == io_id_rs2);

    fc_rs1 = hit_rs1 ? fwd_code : SEL_REG;
    fc_rs2 = hit_rs2 ? fwd_code : SEL_REG;

    if (io_id_valid) begin
      a_sel_nxt   = io_id_a_pc  ? SEL_ALT : fc_rs1;
      b_sel_nxt   = io_id_b_imm ? SEL_ALT : fc_rs2;
      // Store data still needs the forwarded rs2 when B carries the offset.
      rs2_sel_nxt = fc_rs2;
    end

    // rs2 always feeds rs2_sel, so its forward is used even behind an immediate.
    rs1_counts = hit_rs1 & ~io_id_a_pc;
    rs2_counts = hit_rs2;

    alu_inc = (rs1_counts & (fc_rs1 == SEL_ALU)) | (rs2_counts & (fc_rs2 == SEL_ALU));
    mem_inc = (rs1_counts & (fc_rs1 == SEL_MEM)) | (rs2_counts & (fc_rs2 == SEL_MEM));
  end

  assign advance = ~io_stall & ~io_flush;

  // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_rd      <= 5'd0;
      ex_regwen  <= 1'b0;
      ex_is_load <= 1'b0;
      ex_valid   <= 1'b0;
      a_sel_q    <= SEL_REG;
      b_sel_q    <= SEL_REG;
      rs2_sel_q  <= SEL_REG;
      alu_cnt_q  <= '0;
      mem_cnt_q  <= '0;
    end else begin
      // Flush wins over stall: the squashed instruction enters EX as a bubble.
      if (io_flush) begin
        ex_valid  <= 1'b0;
        ex_regwen <= 1'b0;
        a_sel_q   <= SEL_REG;
        b_sel_q   <= SEL_REG;
        rs2_sel_q <= SEL_REG;
      end else if (!io_stall) begin
        ex_rd      <= io_id_rd;
        ex_regwen  <= io_id_regwen;
        ex_is_load <= io_id_is_load;
        ex_valid   <= io_id_valid;
        a_sel_q    <= a_sel_nxt;
        b_sel_q    <= b_sel_nxt;
        rs2_sel_q  <= rs2_sel_nxt;
      end

      if (io_perf_clear) begin
        alu_cnt_q <= '0;
        mem_cnt_q <= '0;
      end else if (advance) begin
        if (alu_inc && (alu_cnt_q != CNT_MAX)) alu_cnt_q <= alu_cnt_q + CNT_W'(1);
        if (mem_inc && (mem_cnt_q != CNT_MAX)) mem_cnt_q <= mem_cnt_q + CNT_W'(1);
      end
    end
  end

  assign io_a_sel       = a_sel_q;
  assign io_b_sel       = b_sel_q;
  assign io_rs2_sel     = rs2_sel_q;
  assign io_ex_valid    = ex_valid;
  assign io_fwd_alu_cnt = alu_cnt_q;
  assign io_fwd_mem_cnt = mem_cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: a default-width instance and a CNT_W=2 instance share all inputs.
module tb_fwd_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwen;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       is_load;
    logic       a_pc;
    logic       b_imm;
  } instr_t;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs2;
    logic       exv;
    int         alu;
    int         mem;
    int         alu_s;
    int         mem_s;
    string      name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_regwen, id_is_load, id_a_pc, id_b_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall, flush, perf_clear;
  logic [1:0]  a_sel, b_sel, rs2_sel, sa_sel, sb_sel, srs2_sel;
  logic        ex_valid, s_ex_valid;
  logic [15:0] alu_cnt, mem_cnt;
  logic [1:0]  s_alu_cnt, s_mem_cnt;

  int   errors = 0;
  int   checks = 0;
  int   exp_alu = 0, exp_mem = 0, exp_alu_s = 0, exp_mem_s = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  fwd_ctrl dut (
    .clock(clock), .reset(reset),
    .io_id_valid(id_valid), .io_id_rs1(id_rs1), .io_id_rs2(id_rs2),
    .io_id_uses_rs1(id_uses_rs1), .io_id_uses_rs2(id_uses_rs2),
    .io_id_rd(id_rd), .io_id_regwen(id_regwen), .io_id_is_load(id_is_load),
    .io_id_a_pc(id_a_pc), .io_id_b_imm(id_b_imm),
    .io_stall(stall), .io_flush(flush), .io_perf_clear(perf_clear),
    .io_a_sel(a_sel), .io_b_sel(b_sel), .io_rs2_sel(rs2_sel), .io_ex_valid(ex_valid),
    .io_fwd_alu_cnt(alu_cnt), .io_fwd_mem_cnt(mem_cnt)
  );

  fwd_ctrl #(.CNT_W(2)) dut_s (
    .clock(clock), .reset(reset),
    .io_id_valid(id_valid), .io_id_rs1(id_rs1), .io_id_rs2(id_rs2),
    .io_id_uses_rs1(id_uses_rs1), .io_id_uses_rs2(id_uses_rs2),
    .io_id_rd(id_rd), .io_id_regwen(id_regwen), .io_id_is_load(id_is_load),
    .io_id_a_pc(id_a_pc), .io_id_b_imm(id_b_imm),
    .io_stall(stall), .io_flush(flush), .io_perf_clear(perf_clear),
    .io_a_sel(sa_sel), .io_b_sel(sb_sel), .io_rs2_sel(srs2_sel), .io_ex_valid(s_ex_valid),
    .io_fwd_alu_cnt(s_alu_cnt), .io_fwd_mem_cnt(s_mem_cnt)
  );

  function automatic instr_t mk(input logic v, input logic [4:0] rd, input logic rw,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic ld, input logic apc, input logic bimm);
    instr_t i;
    i = '{valid: v, rd: rd, regwen: rw, rs1: rs1, u1: u1, rs2: rs2, u2: u2,
          is_load: ld, a_pc: apc, b_imm: bimm};
    return i;
  endfunction

  function automatic instr_t alu_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return mk(1'b1, rd, 1'b1, rs1, 1'b1, rs2, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic instr_t load_op(input logic [4:0] rd, input logic [4:0] rs1);
    return mk(1'b1, rd, 1'b1, rs1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic instr_t store_op(input logic [4:0] rs1, input logic [4:0] rs2);
    return mk(1'b1, 5'd0, 1'b0, rs1, 1'b1, rs2, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic instr_t bubble();
    return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Drives one ID cycle, pushes what EX must show after the edge, then pops and compares.
  task automatic run_cycle(input instr_t ins, input logic rst, input logic stl, input logic fl,
                           input logic clr, input logic [1:0] ea, input logic [1:0] eb,
                           input logic [1:0] er, input logic ev, input logic ialu,
                           input logic imem, input string name);
    exp_t e;
    reset       = rst;
    stall       = stl;
    flush       = fl;
    perf_clear  = clr;
    id_valid    = ins.valid;
    id_rd       = ins.rd;
    id_regwen   = ins.regwen;
    id_rs1      = ins.rs1;
    id_uses_rs1 = ins.u1;
    id_rs2      = ins.rs2;
    id_uses_rs2 = ins.u2;
    id_is_load  = ins.is_load;
    id_a_pc     = ins.a_pc;
    id_b_imm    = ins.b_imm;

    if (rst || clr) begin
      exp_alu = 0; exp_mem = 0; exp_alu_s = 0; exp_mem_s = 0;
    end else if (!stl && !fl) begin
      if (ialu) begin
        if (exp_alu < 65535) exp_alu++;
        if (exp_alu_s < 3) exp_alu_s++;
      end
      if (imem) begin
        if (exp_mem < 65535) exp_mem++;
        if (exp_mem_s < 3) exp_mem_s++;
      end
    end
    e = '{a: ea, b: eb, rs2: er, exv: ev, alu: exp_alu, mem: exp_mem,
          alu_s: exp_alu_s, mem_s: exp_mem_s, name: name};
    sb.push_back(e);

    @(posedge clock);
    #1;

    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, want one entry", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (a_sel !== e.a) begin
        errors++; $display("FAIL %s a_sel: got %0d want %0d", e.name, a_sel, e.a);
      end
      checks++;
      if (b_sel !== e.b) begin
        errors++; $display("FAIL %s b_sel: got %0d want %0d", e.name, b_sel, e.b);
      end
      checks++;
      if (rs2_sel !== e.rs2) begin
        errors++; $display("FAIL %s rs2_sel: got %0d want %0d", e.name, rs2_sel, e.rs2);
      end
      checks++;
      if (ex_valid !== e.exv) begin
        errors++; $display("FAIL %s ex_valid: got %0d want %0d", e.name, ex_valid, e.exv);
      end
      checks++;
      if ({sa_sel, sb_sel, srs2_sel, s_ex_valid} !== {e.a, e.b, e.rs2, e.exv}) begin
        errors++;
        $display("FAIL %s narrow-instance selects: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 e.name, sa_sel, sb_sel, srs2_sel, s_ex_valid, e.a, e.b, e.rs2, e.exv);
      end
      checks++;
      if (alu_cnt !== 16'(e.alu)) begin
        errors++; $display("FAIL %s fwd_alu_cnt: got %0d want %0d", e.name, alu_cnt, e.alu);
      end
      checks++;
      if (mem_cnt !== 16'(e.mem)) begin
        errors++; $display("FAIL %s fwd_mem_cnt: got %0d want %0d", e.name, mem_cnt, e.mem);
      end
      checks++;
      if (s_alu_cnt !== 2'(e.alu_s)) begin
        errors++; $display("FAIL %s narrow fwd_alu_cnt: got %0d want %0d", e.name, s_alu_cnt, e.alu_s);
      end
      checks++;
      if (s_mem_cnt !== 2'(e.mem_s)) begin
        errors++; $display("FAIL %s narrow fwd_mem_cnt: got %0d want %0d", e.name, s_mem_cnt, e.mem_s);
      end
    end
  endtask

  task automatic test_reset();
    run_cycle(alu_op(5'd5, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "reset_with_stall");
    run_cycle(alu_op(5'd5, 5'd0, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "reset_with_flush");
  endtask

  task automatic test_alu_chain();
    run_cycle(alu_op(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "alu_chain_producer");
    run_cycle(alu_op(5'd6, 5'd5, 5'd5), 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, "alu_chain_consumer");
  endtask

  task automatic test_load_use();
    run_cycle(bubble(),               1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "load_use_bubble");
    run_cycle(load_op(5'd7, 5'd1),    1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, "load_use_lw");
    run_cycle(store_op(5'd2, 5'd7),   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, 1'b1, "load_use_store_data");
    run_cycle(load_op(5'd8, 5'd7),    1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, "load_after_store");
    run_cycle(alu_op(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3, 2'd3, 1'b1, 1'b0, 1'b1, "load_use_both_ops");
  endtask

  task automatic test_overrides();
    run_cycle(alu_op(5'd10, 5'd9, 5'd9), 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, "ovr_producer_fwd");
    run_cycle(mk(1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1),
              1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, "ovr_pc_hides_rs1");
    run_cycle(mk(1'b1, 5'd11, 1'b1, 5'd1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0),
              1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, "ovr_pc_rs2_fwd");
    run_cycle(store_op(5'd11, 5'd11), 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, "ovr_store_imm_fwd");
  endtask

  task automatic test_x0_and_invalid();
    run_cycle(bubble(), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "x0_bubble");
    run_cycle(mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
              1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "x0_producer");
    run_cycle(alu_op(5'd12, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "x0_reader");
    run_cycle(mk(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
              1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "noregwen_producer");
    run_cycle(alu_op(5'd13, 5'd3, 5'd3), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "noregwen_reader");
    run_cycle(mk(1'b0, 5'd14, 1'b1, 5'd13, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1),
              1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "invalid_id_no_selects");
    run_cycle(alu_op(5'd15, 5'd14, 5'd14), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "after_invalid_no_hit");
  endtask

  task automatic test_flush();
    run_cycle(alu_op(5'd4, 5'd1, 5'd1),   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "flush_producer");
    run_cycle(alu_op(5'd12, 5'd4, 5'd4),  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "flush_consumer");
    run_cycle(alu_op(5'd13, 5'd4, 5'd4),  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "after_flush_no_hit");
    run_cycle(alu_op(5'd16, 5'd13, 5'd13), 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "flush_beats_stall");
    run_cycle(alu_op(5'd17, 5'd13, 5'd13), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "after_flush_stall");
  endtask

  task automatic test_stall();
    run_cycle(alu_op(5'd5, 5'd1, 5'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "stall_producer");
    run_cycle(alu_op(5'd6, 5'd5, 5'd2), 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, "stall_first_dep");
    for (int i = 0; i < 3; i++)
      run_cycle(alu_op(5'd7, 5'd6, 5'd6), 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, "stall_hold");
    run_cycle(alu_op(5'd7, 5'd6, 5'd6), 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, "stall_release");
  endtask

  task automatic test_back_to_back();
    run_cycle(load_op(5'd20, 5'd7),        1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, "b2b_load");
    run_cycle(alu_op(5'd21, 5'd20, 5'd3),  1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, "b2b_load_use");
    run_cycle(alu_op(5'd22, 5'd21, 5'd21), 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, "b2b_alu1");
    run_cycle(alu_op(5'd23, 5'd22, 5'd20), 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, "b2b_alu2");
  endtask

  task automatic test_saturation();
    run_cycle(bubble(), 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "sat_clear");
    run_cycle(alu_op(5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "sat_head");
    for (int i = 0; i < 5; i++)
      run_cycle(alu_op(5'(i + 2), 5'(i + 1), 5'(i + 1)), 1'b0, 1'b0, 1'b0, 1'b0,
                2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, "sat_alu_chain");
    run_cycle(alu_op(5'd7, 5'd6, 5'd6), 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, "sat_clear_beats_inc");
    run_cycle(alu_op(5'd8, 5'd7, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, "sat_after_clear");
    run_cycle(load_op(5'd9, 5'd8), 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, "sat_load_head");
    for (int i = 0; i < 4; i++)
      run_cycle(load_op(5'(i + 10), 5'(i + 9)), 1'b0, 1'b0, 1'b0, 1'b0,
                2'd3, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, "sat_mem_chain");
  endtask

  task automatic test_reset_mid();
    run_cycle(alu_op(5'd14, 5'd13, 5'd13), 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3, 2'd3, 1'b1, 1'b0, 1'b1, "mid_pre_reset");
    run_cycle(alu_op(5'd15, 5'd14, 5'd14), 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "mid_reset_stall");
    run_cycle(alu_op(5'd16, 5'd14, 5'd14), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "mid_after_reset");
    run_cycle(alu_op(5'd17, 5'd16, 5'd16), 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, "mid_resume_fwd");
    run_cycle(alu_op(5'd18, 5'd17, 5'd17), 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "mid_reset_flush");
    run_cycle(alu_op(5'd19, 5'd17, 5'd17), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "mid_after_reset2");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary by time %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; perf_clear = 1'b0;
    id_valid = 1'b0; id_rd = '0; id_regwen = 1'b0; id_rs1 = '0; id_rs2 = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_is_load = 1'b0; id_a_pc = 1'b0; id_b_imm = 1'b0;
    #2;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_overrides();
    test_x0_and_invalid();
    test_flush();
    test_stall();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding control for the RV151 three-stage pipeline (ID → EX → WB). It sits in ID and tracks the destination register of the instruction one stage ahead. It drives registered select codes into EX that steer the ALU A/B operand muxes and the store-data mux. It also keeps per-event saturating performance counters for forwards taken.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- io_id_valid  in  1  ID holds a real instruction
- io_id_rs1 / io_id_rs2  in  5  source register indices
- io_id_uses_rs1 / io_id_uses_rs2  in  1  instruction reads rs1 / rs2
- io_id_rd  in  5  destination index
- io_id_regwen  in  1  instruction writes rd
- io_id_is_load  in  1  instruction is a load
- io_id_a_pc  in  1  ALU A takes PC
- io_id_b_imm  in  1  ALU B takes immediate
- io_stall  in  1  freeze pipeline this cycle
- io_flush  in  1  squash the ID instruction (turn it into a bubble in EX)
- io_perf_clear  in  1  zero both counters
- io_a_sel  out  2  0 rs1, 1 pc, 2 alu_out, 3 mem_out (registered, consumed in EX)
- io_b_sel  out  2  0 rs2, 1 imm, 2 alu_out, 3 mem_out (registered)
- io_rs2_sel  out  2  store data: 0 rs2, 2 alu_out, 3 mem_out; code 1 never produced
- io_ex_valid  out  1  EX holds a real instruction
- io_fwd_alu_cnt / io_fwd_mem_cnt  out  CNT_W  instructions entering EX with ≥1 alu_out / mem_out forward

## Operation
- State registers: ex_rd, ex_regwen, ex_is_load, ex_valid. These describe the producer P currently in EX. When the consumer C reaches EX, P is in WB. alu_out is P's registered ALU result. mem_out is P's load data.
- Hit rule for a source s ∈ {rs1, rs2}: hit_s = ex_valid & ex_regwen & (ex_rd ≠ 0) & (ex_rd == id_s) & id_uses_s.
- Forward code: fc_s = ex_is_load ? 3 : 2 when hit_s, else 0.
- Next a_sel: id_a_pc ? 1 : fc_rs1. Next b_sel: id_b_imm ? 1 : fc_rs2. Next rs2_sel: fc_rs2, so stores with an imm B still forward store data.
- An ID instruction with id_valid=0 produces all selects 0 and no hit effect.
- x0 is never forwarded, even when rd=0 and regwen=1.
- Producers two or more stages ahead are not handled here. The register file write-first path covers them.
- Advance (io_stall=0, io_flush=0): selects ← next values; ex_* ← id_*; ex_valid ← id_valid.
- Flush (io_flush=1): selects ← 0, ex_valid ← 0, ex_regwen ← 0. Flush has priority over stall.
- Stall only (io_stall=1, io_flush=0): every register holds, counters included.
- Counters update only on advance with id_valid=1:
  - io_fwd_alu_cnt +1 if any of fc_rs1/fc_rs2 is 2 and actually used. A source counts as used if it drives rs2_sel, or it is not overridden by pc/imm.
  - io_fwd_mem_cnt +1 likewise for code 3.
  - Both counters saturate at 2^CNT_W−1.
  - io_perf_clear zeros both and takes priority over increment in the same cycle.

## Timing
- Reset: all outputs 0, all ex_* 0, both counters 0. Takes effect at the first rising edge with reset high, regardless of stall or flush.
- Latency: selects for C are visible on outputs exactly 1 cycle after C's last ID cycle, and hold for C's EX cycle.
- No combinational path from any input to any output.
- Back-to-back dependents forward each cycle with no bubble. Load-use forwards mem_out (code 3) with no stall inserted.
- Stall held N cycles: outputs frozen N cycles, then resume using the ID contents present on the releasing cycle.
- Reset asserted mid-stream (including during stall or flush): the next cycle outputs all 0 and EX is empty. The following instruction sees no hit.

## Test plan
- ALU chain: cycle 0 ID `add x5` (rd=5, regwen); cycle 1 ID `sub` with rs1=5, rs2=5. Expect at cycle 2 a_sel=2, b_sel=2, rs2_sel=2; fwd_alu_cnt=1.
- Load-use: `lw x7` then a store with rs2=7 and b_imm=1. Expect b_sel=1, rs2_sel=3, a_sel=0; fwd_mem_cnt=1, fwd_alu_cnt=0.
- x0 and no-regwen: producer rd=0 regwen=1, then a consumer reading x0 → selects 0. Producer rd=3 regwen=0, then a consumer reading x3 → selects 0. Counters unchanged.
- Flush: `add x4`, then a consumer of x4 with io_flush=1 in its ID cycle. Expect next-cycle selects 0 and ex_valid=0. The following x4 reader sees no hit because the bubble cleared regwen.
- Stall: dependent pair, with io_stall=1 for 3 cycles while the consumer sits in ID. Outputs hold their prior values for 3 cycles, then a_sel=2 appears one cycle after release. Counter increments once.
- Saturation/clear: CNT_W=2, 5 forwarding instructions → fwd_alu_cnt=3. Then io_perf_clear together with a forward → 0. Reset mid-chain → all outputs 0 next cycle.
